writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL provide ports (name direction width meaning), clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- M_valid  in  1  M stage holds a real instruction (0 = bubble).
- M_PC  in  32  PC of the M-stage instruction.
- M_instr  in  32  M-stage instruction word.
- M_A3  in  5  destination register number.
- M_ALUout  in  32  ALU result; also the data memory address.
- M_DMout  in  32  raw aligned word read from data memory.
- M_WDsel  in  2  result source: 0 ALU, 1 memory, 2 PC+8, 3 reserved.
- M_memtype  in  3  load type: 0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu, others reserved.
- W_valid  out  1  W stage holds a real instruction.
- W_PC  out  32  PC of the W-stage instruction, to the GRF write port and trace.
- W_instr  out  32  W-stage instruction word.
- W_A3  out  5  GRF write address; 0 means no write.
- W_WD  out  32  GRF write data; also the W-stage forwarding value.
- W_retired  out  32  retired-instruction count (see Configuration).

Function
REQ-002 SHALL register all M inputs into an M/W pipeline register on every rising clk edge; the block has no stall input and never holds.
REQ-003 SHALL present registered values on W_valid, W_PC, W_instr one cycle after capture; latency M to W is exactly 1 cycle.
REQ-004 SHALL drive W_A3 = registered M_A3 when registered valid=1, else 5'd0; a bubble never writes the GRF.
REQ-005 SHALL compute W_WD combinationally from registered fields only, never from live M inputs, so W_WD is stable for the whole cycle.
REQ-006 SHALL select W_WD by registered WDsel: 0 gives ALUout; 1 gives the extended load data; 2 gives PC+8 (32-bit wrap, carry discarded); 3 gives 32'd0.
REQ-007 SHALL extend load data using registered ALUout[1:0] as the byte offset:
- lw: the whole word.
- lh/lhu: the halfword selected by addr[1] (0 = bits 15:0, 1 = bits 31:16); sign-extend for lh, zero-extend for lhu; addr[0] is ignored.
- lb/lbu: the byte selected by addr[1:0] (0 = bits 7:0 ... 3 = bits 31:24); sign-extend for lb, zero-extend for lbu.
- reserved memtype: behave as lw.
REQ-008 SHALL pass W_A3=0 through unchanged with whatever W_WD is computed; the GRF ignores register 0.
REQ-009 SHALL forward W_WD/W_A3 to the decode-stage forwarding muxes in the same cycle the GRF write occurs; the Tnew of the W stage is 0.
REQ-010 SHALL contain no combinational path from any M input to any output.

Reset
REQ-011 SHALL, on a clk edge with reset=1, clear the pipeline register: W_valid=0, W_PC=32'h0000_3000, W_instr=0, W_A3=0, stored ALUout/DMout=0, WDsel=0, memtype=0; W_WD therefore reads 0.
REQ-012 SHALL give reset priority over capture; if reset is asserted mid-stream, the instruction in M that cycle is discarded and not retired.
REQ-013 SHALL clear W_retired to 0 on reset when the counter is compiled in.

Configuration
REQ-014 SHALL use macro WB_RETIRE_CNT_EN:
- Defined: W_retired is a 32-bit register that increments by 1 on every non-reset edge on which the captured M_valid=1, and wraps from 32'hFFFF_FFFF to 0.
- Undefined: no counter logic is built and W_retired is tied to 32'd0.
- The port list is identical in both builds.

Verification
REQ-015 SHALL cover these directed scenarios:
- Reset, then idle: reset=1 for 1 edge -> W_valid=0, W_A3=0, W_PC=32'h0000_3000, W_WD=0, W_retired=0.
- ALU op: M_valid=1, M_A3=5, M_WDsel=0, M_ALUout=32'h1234_5678 -> next cycle W_A3=5, W_WD=32'h1234_5678.
- Byte loads: M_DMout=32'h80FF_7F01, M_WDsel=1:
  - lb, ALUout[1:0]=3 -> W_WD=32'hFFFF_FF80.
  - lbu, offset 3 -> 32'h0000_0080.
  - lb, offset 0 -> 32'h0000_0001.
- Halfword loads: M_DMout=32'h8001_FFFE:
  - lh, addr[1]=1 -> W_WD=32'hFFFF_8001.
  - lhu, addr[1]=0 -> 32'h0000_FFFE.
- Link: M_WDsel=2, M_PC=32'hFFFF_FFFC, M_A3=31 -> W_WD=32'h0000_0004, W_A3=31.
- Bubble and counter (WB_RETIRE_CNT_EN defined): three valid instructions, one bubble with M_A3=7, then reset asserted while M_valid=1 -> bubble cycle gives W_A3=0; W_retired reads 3 before reset and 0 after. Same run with the macro undefined -> W_retired=0 throughout.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: M/W pipeline register plus GRF write-data selection and load extension.
// Latency: one clk from M inputs to every W output; W_WD is built from registered fields only.
// Backpressure: none. There is no stall input, and a new M instruction is captured on every edge.
// Optional retire counter: build with WB_RETIRE_CNT_EN defined to enable W_retired.
module writeback_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_valid,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_instr,
  input  logic [4:0]  M_A3,
  input  logic [31:0] M_ALUout,
  input  logic [31:0] M_DMout,
  input  logic [1:0]  M_WDsel,
  input  logic [2:0]  M_memtype,
  output logic        W_valid,
  output logic [31:0] W_PC,
  output logic [31:0] W_instr,
  output logic [4:0]  W_A3,
  output logic [31:0] W_WD,
  output logic [31:0] W_retired
);

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;

  localparam logic [1:0]  WD_ALU     = 2'd0;
  localparam logic [1:0]  WD_MEM     = 2'd1;
  localparam logic [1:0]  WD_LINK    = 2'd2;

  localparam logic [2:0]  MT_LW      = 3'd0;
  localparam logic [2:0]  MT_LH      = 3'd1;
  localparam logic [2:0]  MT_LHU     = 3'd2;
  localparam logic [2:0]  MT_LB      = 3'd3;
  localparam logic [2:0]  MT_LBU     = 3'd4;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [4:0]  r_a3;
  logic [31:0] r_alu;
  logic [31:0] r_dm;
  logic [1:0]  r_wdsel;
  logic [2:0]  r_memtype;

  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [31:0] ld_data;

  // M/W pipeline register; reset wins over capture, so the M instruction in a reset cycle is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_a3      <= 5'd0;
      r_alu     <= 32'd0;
      r_dm      <= 32'd0;
      r_wdsel   <= 2'd0;
      r_memtype <= 3'd0;
    end else begin
      r_valid   <= M_valid;
      r_pc      <= M_PC;
      r_instr   <= M_instr;
      r_a3      <= M_A3;
      r_alu     <= M_ALUout;
      r_dm      <= M_DMout;
      r_wdsel   <= M_WDsel;
      r_memtype <= M_memtype;
    end
  end

  // Pick the addressed halfword/byte out of the aligned memory word; addr[0] plays no part for halfwords
  always_comb begin
    ld_half = r_alu[1] ? r_dm[31:16] : r_dm[15:0];
    ld_byte = r_dm[7:0];
    case (r_alu[1:0])
      2'd0:    ld_byte = r_dm[7:0];
      2'd1:    ld_byte = r_dm[15:8];
      2'd2:    ld_byte = r_dm[23:16];
      default: ld_byte = r_dm[31:24];
    endcase
  end

  // Sign/zero extension by load type; reserved encodings fall back to a full-word load
  always_comb begin
    ld_data = r_dm;
    case (r_memtype)
      MT_LW:   ld_data = r_dm;
      MT_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      MT_LHU:  ld_data = {16'd0, ld_half};
      MT_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      MT_LBU:  ld_data = {24'd0, ld_byte};
      default: ld_data = r_dm;
    endcase
  end

  // Write-data select; this same value feeds the decode-stage forwarding muxes (W-stage Tnew is 0)
  always_comb begin
    W_WD = 32'd0;
    case (r_wdsel)
      WD_ALU:  W_WD = r_alu;
      WD_MEM:  W_WD = ld_data;
      WD_LINK: W_WD = r_pc + 32'd8;
      default: W_WD = 32'd0;
    endcase
  end

  assign W_valid = r_valid;
  assign W_PC    = r_pc;
  assign W_instr = r_instr;
  // A bubble must never write the register file
  assign W_A3    = r_valid ? r_a3 : 5'd0;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_cnt;

  // Count each real instruction as it enters W; wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= 32'd0;
    end else if (M_valid) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end

  assign W_retired = retired_cnt;
`else
  assign W_retired = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed table-driven check of writeback_stage.
// Each table row is one M-stage instruction and the W outputs expected one cycle later.
// Hand-written sequences cover reset, input isolation of W_WD, bubbles and the retire counter.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        M_valid;
  logic [31:0] M_PC;
  logic [31:0] M_instr;
  logic [4:0]  M_A3;
  logic [31:0] M_ALUout;
  logic [31:0] M_DMout;
  logic [1:0]  M_WDsel;
  logic [2:0]  M_memtype;
  logic        W_valid;
  logic [31:0] W_PC;
  logic [31:0] W_instr;
  logic [4:0]  W_A3;
  logic [31:0] W_WD;
  logic [31:0] W_retired;

  int total;
  int bad;
  int exp_cnt;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  a3;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [1:0]  wdsel;
    logic [2:0]  memtype;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t tbl [17];

  writeback_stage dut (
    .clk       (clk),
    .reset     (reset),
    .M_valid   (M_valid),
    .M_PC      (M_PC),
    .M_instr   (M_instr),
    .M_A3      (M_A3),
    .M_ALUout  (M_ALUout),
    .M_DMout   (M_DMout),
    .M_WDsel   (M_WDsel),
    .M_memtype (M_memtype),
    .W_valid   (W_valid),
    .W_PC      (W_PC),
    .W_instr   (W_instr),
    .W_A3      (W_A3),
    .W_WD      (W_WD),
    .W_retired (W_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_retired();
`ifdef WB_RETIRE_CNT_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input vec_t v);
    M_valid   = v.valid;
    M_PC      = v.pc;
    M_instr   = v.instr;
    M_A3      = v.a3;
    M_ALUout  = v.alu;
    M_DMout   = v.dm;
    M_WDsel   = v.wdsel;
    M_memtype = v.memtype;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = 0;

    //            name          vld   pc             instr          a3  alu            dm             sel   mt    ea3 ewd
    tbl[0]  = '{"alu",        1'b1, 32'h0000_3000, 32'h0085_2021, 5,  32'h1234_5678, 32'h0,         2'd0, 3'd0, 5,  32'h1234_5678};
    tbl[1]  = '{"lb_off3",    1'b1, 32'h0000_3004, 32'h8000_0001, 8,  32'h0000_1003, 32'h80FF_7F01, 2'd1, 3'd3, 8,  32'hFFFF_FF80};
    tbl[2]  = '{"lbu_off3",   1'b1, 32'h0000_3008, 32'h9000_0002, 9,  32'h0000_1003, 32'h80FF_7F01, 2'd1, 3'd4, 9,  32'h0000_0080};
    tbl[3]  = '{"lb_off0",    1'b1, 32'h0000_300C, 32'h8000_0003, 10, 32'h0000_1000, 32'h80FF_7F01, 2'd1, 3'd3, 10, 32'h0000_0001};
    tbl[4]  = '{"lb_off1",    1'b1, 32'h0000_3010, 32'h8000_0004, 11, 32'h0000_1001, 32'h80FF_7F01, 2'd1, 3'd3, 11, 32'h0000_007F};
    tbl[5]  = '{"lbu_off2",   1'b1, 32'h0000_3014, 32'h9000_0005, 12, 32'h0000_1002, 32'h80FF_7F01, 2'd1, 3'd4, 12, 32'h0000_00FF};
    tbl[6]  = '{"lh_hi",      1'b1, 32'h0000_3018, 32'h8400_0006, 13, 32'h0000_2002, 32'h8001_FFFE, 2'd1, 3'd1, 13, 32'hFFFF_8001};
    tbl[7]  = '{"lhu_lo",     1'b1, 32'h0000_301C, 32'h9400_0007, 14, 32'h0000_2000, 32'h8001_FFFE, 2'd1, 3'd2, 14, 32'h0000_FFFE};
    tbl[8]  = '{"lh_addr1",   1'b1, 32'h0000_3020, 32'h8400_0008, 15, 32'h0000_2001, 32'h8001_FFFE, 2'd1, 3'd1, 15, 32'hFFFF_FFFE};
    tbl[9]  = '{"lhu_addr3",  1'b1, 32'h0000_3024, 32'h9400_0009, 16, 32'h0000_2003, 32'h8001_FFFE, 2'd1, 3'd2, 16, 32'h0000_8001};
    tbl[10] = '{"lw",         1'b1, 32'h0000_3028, 32'h8C00_000A, 17, 32'h0000_2003, 32'h8001_FFFE, 2'd1, 3'd0, 17, 32'h8001_FFFE};
    tbl[11] = '{"rsvd_mt",    1'b1, 32'h0000_302C, 32'h8C00_000B, 18, 32'h0000_2001, 32'hA5C3_0F96, 2'd1, 3'd6, 18, 32'hA5C3_0F96};
    tbl[12] = '{"link_wrap",  1'b1, 32'hFFFF_FFFC, 32'h0C00_000C, 31, 32'h1111_1111, 32'h2222_2222, 2'd2, 3'd0, 31, 32'h0000_0004};
    tbl[13] = '{"link",       1'b1, 32'h0000_3000, 32'h0C00_000D, 31, 32'h1111_1111, 32'h2222_2222, 2'd2, 3'd3, 31, 32'h0000_3008};
    tbl[14] = '{"wdsel3",     1'b1, 32'h0000_3030, 32'h0000_000E, 4,  32'h3333_3333, 32'h4444_4444, 2'd3, 3'd0, 4,  32'h0000_0000};
    tbl[15] = '{"bubble",     1'b0, 32'h0000_3034, 32'h0000_000F, 7,  32'hDEAD_BEEF, 32'h0,         2'd0, 3'd0, 0,  32'hDEAD_BEEF};
    tbl[16] = '{"a3_zero",    1'b1, 32'h0000_3038, 32'h0000_0010, 0,  32'hCAFE_F00D, 32'h0,         2'd0, 3'd0, 0,  32'hCAFE_F00D};

    // Reset, then idle
    reset = 1'b1;
    drive(tbl[0]);
    step();
    reset = 1'b0;
    M_valid = 1'b0;
    check("rst_valid",   {31'd0, W_valid}, 32'd0);
    check("rst_a3",      {27'd0, W_A3},    32'd0);
    check("rst_pc",      W_PC,             32'h0000_3000);
    check("rst_instr",   W_instr,          32'd0);
    check("rst_wd",      W_WD,             32'd0);
    check("rst_retired", W_retired,        32'd0);

    // Table: one row per cycle, compared one cycle after capture
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i]);
      step();
      if (tbl[i].valid) exp_cnt++;
      check({tbl[i].name, "_valid"}, {31'd0, W_valid}, {31'd0, tbl[i].valid});
      check({tbl[i].name, "_pc"},    W_PC,             tbl[i].pc);
      check({tbl[i].name, "_instr"}, W_instr,          tbl[i].instr);
      check({tbl[i].name, "_a3"},    {27'd0, W_A3},    {27'd0, tbl[i].exp_a3});
      check({tbl[i].name, "_wd"},    W_WD,             tbl[i].exp_wd);
      check({tbl[i].name, "_ret"},   W_retired,        exp_retired());
    end

    // W_WD must not follow live M inputs during the cycle
    drive(tbl[1]);
    step();
    exp_cnt++;
    M_ALUout  = 32'h0000_0000;
    M_DMout   = 32'h1234_5601;
    M_WDsel   = 2'd0;
    M_memtype = 3'd4;
    M_A3      = 5'd3;
    #2;
    check("iso_wd", W_WD,          32'hFFFF_FF80);
    check("iso_a3", {27'd0, W_A3}, 32'd8);

    // Bubble and counter: reset, three valid, one bubble (A3=7), then reset while M_valid=1
    reset = 1'b1;
    drive(tbl[0]);
    step();
    reset   = 1'b0;
    exp_cnt = 0;
    check("seq_rst_ret", W_retired, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(tbl[k]);
      step();
      exp_cnt++;
    end
    check("seq_three_ret", W_retired, exp_retired());
    drive(tbl[15]);
    step();
    check("seq_bubble_a3",  {27'd0, W_A3},    32'd0);
    check("seq_bubble_vld", {31'd0, W_valid}, 32'd0);
    check("seq_bubble_ret", W_retired,        exp_retired());
    drive(tbl[2]);
    reset = 1'b1;
    step();
    reset   = 1'b0;
    exp_cnt = 0;
    M_valid = 1'b0;
    check("seq_mid_rst_vld", {31'd0, W_valid}, 32'd0);
    check("seq_mid_rst_a3",  {27'd0, W_A3},    32'd0);
    check("seq_mid_rst_pc",  W_PC,             32'h0000_3000);
    check("seq_mid_rst_wd",  W_WD,             32'd0);
    check("seq_mid_rst_ret", W_retired,        32'd0);
    step();
    check("seq_idle_ret", W_retired, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
